// File: rtl/lcd_ahb_regs.sv
// AHB-Lite register block that drives the LCD core control inputs (enable, command
// pulses, drawing window) and sequences the panel reset line after power-up or SWRST.
module lcd_ahb_regs #(
    parameter int RST_LOW_CYC  = 50000,
    parameter int RST_WAIT_CYC = 6000000,
    parameter int CNT_W        = 24
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        lcd_rstn,
    output logic        en,
    output logic        ini_en,
    output logic        color_en,
    output logic [31:0] set_sc,
    output logic [31:0] set_ec,
    output logic [31:0] set_sp,
    output logic [31:0] set_ep
);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_IDLE   = 2'd2
    } seq_state_t;

    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Merge write data into a register, one byte lane at a time.
    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic             r_dp_valid;
    logic             r_dp_write;
    logic [2:0]       r_dp_addr;
    logic [3:0]       r_dp_mask;
    logic             r_en;
    logic             r_ini_en;
    logic             r_color_en;
    logic [31:0]      r_sc;
    logic [31:0]      r_ec;
    logic [31:0]      r_sp;
    logic [31:0]      r_ep;
    seq_state_t       r_state;
    seq_state_t       w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;

    logic       w_addr_ph;
    logic [3:0] w_lane_mask;
    logic       w_wr;
    logic       w_rd;
    logic       w_ctrl_wr;
    logic       w_swrst;
    logic       w_idle;
    logic       w_unused_bits;

    assign w_addr_ph     = HSEL & HREADY & HTRANS[1];
    assign w_wr          = r_dp_valid & r_dp_write;
    assign w_rd          = r_dp_valid & ~r_dp_write;
    assign w_ctrl_wr     = w_wr & (r_dp_addr == 3'd0) & r_dp_mask[0];
    assign w_swrst       = w_ctrl_wr & HWDATA[3];
    assign w_idle        = (r_state == ST_IDLE);
    assign w_unused_bits = ^{HADDR[31:5], HTRANS[0]};

    // Byte-lane mask of the transfer being addressed.
    always_comb begin
        w_lane_mask = 4'b0000;
        case (HSIZE)
            3'b000:  w_lane_mask = 4'b0001 << HADDR[1:0];
            3'b001:  w_lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_lane_mask = 4'b1111;
        endcase
    end

    // Address-phase capture; the data phase always completes in the following cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= 3'd0;
            r_dp_mask  <= 4'd0;
        end else begin
            r_dp_valid <= w_addr_ph;
            if (w_addr_ph) begin
                r_dp_write <= HWRITE;
                r_dp_addr  <= HADDR[4:2];
                r_dp_mask  <= w_lane_mask;
            end
        end
    end

    // Control, pulse and window registers written at the end of the data phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_en       <= 1'b0;
            r_ini_en   <= 1'b0;
            r_color_en <= 1'b0;
            r_sc       <= 32'd0;
            r_ec       <= 32'd0;
            r_sp       <= 32'd0;
            r_ep       <= 32'd0;
        end else begin
            // Commands are dropped, not queued, unless the panel is out of reset.
            r_ini_en   <= w_ctrl_wr & HWDATA[1] & ~HWDATA[3] & w_idle;
            r_color_en <= w_ctrl_wr & HWDATA[2] & ~HWDATA[3] & w_idle;
            if (w_ctrl_wr) begin
                r_en <= HWDATA[0];
            end
            if (w_wr && (r_dp_addr == 3'd1)) r_sc <= f_merge(r_sc, HWDATA, r_dp_mask);
            if (w_wr && (r_dp_addr == 3'd2)) r_ec <= f_merge(r_ec, HWDATA, r_dp_mask);
            if (w_wr && (r_dp_addr == 3'd3)) r_sp <= f_merge(r_sp, HWDATA, r_dp_mask);
            if (w_wr && (r_dp_addr == 3'd4)) r_ep <= f_merge(r_ep, HWDATA, r_dp_mask);
        end
    end

    // Panel reset sequencer state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Sequencer next state; SWRST restarts the low period from any state.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (w_swrst) begin
            w_state_nx = ST_ASSERT;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (r_cnt == LOW_LAST) begin
                        w_state_nx = ST_WAIT;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx   = r_cnt + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx   = r_cnt + CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    w_cnt_nx = '0;
                end
                default: begin
                    w_state_nx = ST_ASSERT;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // Read mux, driven only while a read data phase is in progress.
    always_comb begin
        HRDATA = 32'd0;
        if (w_rd) begin
            case (r_dp_addr)
                3'd0:    HRDATA = {31'd0, r_en};
                3'd1:    HRDATA = r_sc;
                3'd2:    HRDATA = r_ec;
                3'd3:    HRDATA = r_sp;
                3'd4:    HRDATA = r_ep;
                3'd5:    HRDATA = {30'd0, lcd_rstn, ~w_idle};
                default: HRDATA = 32'd0;
            endcase
        end else begin
            HRDATA = 32'd0;
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign lcd_rstn  = (r_state != ST_ASSERT);
    assign en        = r_en & w_idle;
    assign ini_en    = r_ini_en;
    assign color_en  = r_color_en;
    assign set_sc    = r_sc;
    assign set_ec    = r_ec;
    assign set_sp    = r_sp;
    assign set_ep    = r_ep;

endmodule
